wb_stage_tlbwait: RTL and testbench

- Parametrised writeback stage for the pipelined LoongArch-style CPU; sits between the MEM stage and the register file, CSR file and TLB.
- Commits GPR and CSR writes, reports exceptions and ertn, and raises a refetch flush after TLB ops and translation-affecting CSR writes.
- TLB ops (tlbwr/tlbfill/tlbrd) are multi-cycle: they use a req/ack handshake with the TLB instead of committing unconditionally in one cycle.
- Keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_stage_tlbwait.sv | 193 +++++++++++++++++++
 tb/tb_wb_stage_tlbwait.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states, CSR numbers
// whose writes change address translation, and TLB op bit positions.
package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_TLB_ISSUE = 2'd2,
      ST_TLB_WAIT  = 2'd3
   } wb_state_e;

   localparam logic [13:0] CSR_CRMD = 14'h000;
   localparam logic [13:0] CSR_ASID = 14'h018;
   localparam logic [13:0] CSR_DMW0 = 14'h180;
   localparam logic [13:0] CSR_DMW1 = 14'h181;

   // bit positions inside the 3-bit {tlbwr, tlbfill, tlbrd} op field
   localparam int TLB_OP_WR   = 2;
   localparam int TLB_OP_FILL = 1;
   localparam int TLB_OP_RD   = 0;

endpackage

// File: rtl/wb_stage_tlbwait.sv
// Writeback stage: commits GPR/CSR writes, reports exceptions/ertn, and holds
// TLB ops in a req/ack handshake before raising a refetch flush.
//
// state        | meaning
// ST_IDLE      | no entry held
// ST_RUN       | entry held, non-TLB or faulting; commits this cycle
// ST_TLB_ISSUE | TLB entry, first cycle (CSR settle, no request yet)
// ST_TLB_WAIT  | tlb_req outstanding, commits on tlb_ack
module wb_stage_tlbwait
   import wb_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RADDR_W   = 5,
   parameter int CSR_NUM_W = 14,
   parameter int EXC_W     = 6,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_to_wb_valid,
   output logic                 wb_allowin,
   input  logic [XLEN-1:0]      mem_pc,
   input  logic                 mem_rf_we,
   input  logic [RADDR_W-1:0]   mem_rf_waddr,
   input  logic [XLEN-1:0]      mem_rf_wdata,
   input  logic                 mem_csr_re,
   input  logic                 mem_csr_we,
   input  logic [CSR_NUM_W-1:0] mem_csr_num,
   input  logic [XLEN-1:0]      mem_csr_mask,
   input  logic [XLEN-1:0]      mem_csr_wvalue,
   input  logic [EXC_W-1:0]     mem_exc,
   input  logic                 mem_ertn,
   input  logic [XLEN-1:0]      mem_fault_vaddr,
   input  logic [2:0]           mem_tlb_op,
   output logic                 wb_valid,
   output logic                 rf_we,
   output logic [RADDR_W-1:0]   rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 fwd_valid,
   output logic [RADDR_W-1:0]   fwd_addr,
   output logic [XLEN-1:0]      fwd_data,
   output logic                 csr_re,
   output logic [CSR_NUM_W-1:0] csr_num,
   input  logic [XLEN-1:0]      csr_rvalue,
   output logic                 csr_we,
   output logic [XLEN-1:0]      csr_wmask,
   output logic [XLEN-1:0]      csr_wvalue,
   output logic [EXC_W-1:0]     wb_exc,
   output logic [XLEN-1:0]      wb_fault_vaddr,
   output logic                 ertn_flush,
   output logic                 tlb_req,
   output logic [2:0]           tlb_op,
   input  logic                 tlb_ack,
   output logic                 refetch_flush,
   output logic [XLEN-1:0]      refetch_pc,
   output logic [CNT_W-1:0]     retire_cnt
);

   wb_state_e            state_q, state_d;
   logic [XLEN-1:0]      pc_q, pc_d;
   logic                 rf_we_q, rf_we_d;
   logic [RADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
   logic                 csr_re_q, csr_re_d;
   logic                 csr_we_q, csr_we_d;
   logic [CSR_NUM_W-1:0] csr_num_q, csr_num_d;
   logic [XLEN-1:0]      csr_mask_q, csr_mask_d;
   logic [XLEN-1:0]      csr_wvalue_q, csr_wvalue_d;
   logic [EXC_W-1:0]     exc_q, exc_d;
   logic                 ertn_q, ertn_d;
   logic [XLEN-1:0]      fault_vaddr_q, fault_vaddr_d;
   logic [2:0]           tlb_op_q, tlb_op_d;
   logic [CNT_W-1:0]     retire_cnt_q, retire_cnt_d;

   logic ready_go, commit, exc_none, xlate_csr, refetch, flush_any, accept;

   always_comb begin
      ready_go = 1'b0;
      case (state_q)
         ST_RUN:      ready_go = 1'b1;
         ST_TLB_WAIT: ready_go = tlb_ack;
         default:     ready_go = 1'b0;
      endcase
   end

   assign wb_valid   = (state_q != ST_IDLE);
   assign commit     = wb_valid & ready_go;
   assign exc_none   = (exc_q == '0);
   assign xlate_csr  = (csr_num_q == CSR_NUM_W'(CSR_CRMD)) | (csr_num_q == CSR_NUM_W'(CSR_ASID))
                     | (csr_num_q == CSR_NUM_W'(CSR_DMW0)) | (csr_num_q == CSR_NUM_W'(CSR_DMW1));
   assign refetch    = exc_none & ((tlb_op_q != 3'b000) | (csr_we_q & xlate_csr));
   assign flush_any  = commit & (~exc_none | ertn_q | refetch);
   // a flushing commit must not let the squashed younger entry in
   assign wb_allowin = ~wb_valid | (ready_go & ~flush_any);
   assign accept     = mem_to_wb_valid & wb_allowin;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      rf_we_d       = rf_we_q;
      rf_waddr_d    = rf_waddr_q;
      rf_wdata_d    = rf_wdata_q;
      csr_re_d      = csr_re_q;
      csr_we_d      = csr_we_q;
      csr_num_d     = csr_num_q;
      csr_mask_d    = csr_mask_q;
      csr_wvalue_d  = csr_wvalue_q;
      exc_d         = exc_q;
      ertn_d        = ertn_q;
      fault_vaddr_d = fault_vaddr_q;
      tlb_op_d      = tlb_op_q;
      retire_cnt_d  = retire_cnt_q;
      if (commit & exc_none)
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (accept) begin
         pc_d          = mem_pc;
         rf_we_d       = mem_rf_we;
         rf_waddr_d    = mem_rf_waddr;
         rf_wdata_d    = mem_rf_wdata;
         csr_re_d      = mem_csr_re;
         csr_we_d      = mem_csr_we;
         csr_num_d     = mem_csr_num;
         csr_mask_d    = mem_csr_mask;
         csr_wvalue_d  = mem_csr_wvalue;
         exc_d         = mem_exc;
         ertn_d        = mem_ertn;
         fault_vaddr_d = mem_fault_vaddr;
         tlb_op_d      = mem_tlb_op;
         state_d       = ((mem_tlb_op != 3'b000) && (mem_exc == '0)) ? ST_TLB_ISSUE : ST_RUN;
      end else if (commit) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_TLB_ISSUE) begin
         state_d = ST_TLB_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         rf_we_q       <= 1'b0;
         rf_waddr_q    <= '0;
         rf_wdata_q    <= '0;
         csr_re_q      <= 1'b0;
         csr_we_q      <= 1'b0;
         csr_num_q     <= '0;
         csr_mask_q    <= '0;
         csr_wvalue_q  <= '0;
         exc_q         <= '0;
         ertn_q        <= 1'b0;
         fault_vaddr_q <= '0;
         tlb_op_q      <= 3'b000;
         retire_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rf_we_q       <= rf_we_d;
         rf_waddr_q    <= rf_waddr_d;
         rf_wdata_q    <= rf_wdata_d;
         csr_re_q      <= csr_re_d;
         csr_we_q      <= csr_we_d;
         csr_num_q     <= csr_num_d;
         csr_mask_q    <= csr_mask_d;
         csr_wvalue_q  <= csr_wvalue_d;
         exc_q         <= exc_d;
         ertn_q        <= ertn_d;
         fault_vaddr_q <= fault_vaddr_d;
         tlb_op_q      <= tlb_op_d;
         retire_cnt_q  <= retire_cnt_d;
      end
   end

   assign rf_we          = commit & exc_none & rf_we_q;
   assign rf_waddr       = rf_waddr_q;
   assign rf_wdata       = csr_re_q ? csr_rvalue : rf_wdata_q;
   assign fwd_valid      = wb_valid & rf_we_q & exc_none;
   assign fwd_addr       = rf_waddr_q;
   assign fwd_data       = rf_wdata;
   assign csr_re         = wb_valid & csr_re_q;
   assign csr_num        = csr_num_q;
   assign csr_we         = commit & exc_none & csr_we_q;
   assign csr_wmask      = csr_mask_q;
   assign csr_wvalue     = csr_wvalue_q;
   assign wb_exc         = commit ? exc_q : '0;
   assign wb_fault_vaddr = fault_vaddr_q;
   assign ertn_flush     = commit & ertn_q & exc_none;
   assign tlb_req        = (state_q == ST_TLB_WAIT);
   assign tlb_op         = tlb_req ? tlb_op_q : 3'b000;
   assign refetch_flush  = commit & refetch;
   assign refetch_pc     = pc_q + XLEN'(4);
   assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_tlbwait.sv
// Bench for wb_stage_tlbwait: directed scenarios plus a randomized run checked
// against an entry/age model of the stage.
module tb_wb_stage_tlbwait;
   import wb_pkg::*;

   localparam int CW = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_to_wb_valid;
   logic        wb_allowin;
   logic [31:0] mem_pc;
   logic        mem_rf_we;
   logic [4:0]  mem_rf_waddr;
   logic [31:0] mem_rf_wdata;
   logic        mem_csr_re, mem_csr_we;
   logic [13:0] mem_csr_num;
   logic [31:0] mem_csr_mask, mem_csr_wvalue;
   logic [5:0]  mem_exc;
   logic        mem_ertn;
   logic [31:0] mem_fault_vaddr;
   logic [2:0]  mem_tlb_op;
   logic        wb_valid, rf_we, fwd_valid, csr_re, csr_we, ertn_flush, tlb_req, refetch_flush;
   logic [4:0]  rf_waddr, fwd_addr;
   logic [31:0] rf_wdata, fwd_data, csr_rvalue, csr_wmask, csr_wvalue, wb_fault_vaddr, refetch_pc;
   logic [13:0] csr_num;
   logic [5:0]  wb_exc;
   logic [2:0]  tlb_op;
   logic        tlb_ack;
   logic [CW-1:0] retire_cnt;

   int checks = 0;
   int failures = 0;

   wb_stage_tlbwait #(.XLEN(32), .RADDR_W(5), .CSR_NUM_W(14), .EXC_W(6), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
      .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr), .mem_rf_wdata(mem_rf_wdata),
      .mem_csr_re(mem_csr_re), .mem_csr_we(mem_csr_we), .mem_csr_num(mem_csr_num),
      .mem_csr_mask(mem_csr_mask), .mem_csr_wvalue(mem_csr_wvalue), .mem_exc(mem_exc),
      .mem_ertn(mem_ertn), .mem_fault_vaddr(mem_fault_vaddr), .mem_tlb_op(mem_tlb_op),
      .wb_valid(wb_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
      .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
      .wb_exc(wb_exc), .wb_fault_vaddr(wb_fault_vaddr), .ertn_flush(ertn_flush),
      .tlb_req(tlb_req), .tlb_op(tlb_op), .tlb_ack(tlb_ack),
      .refetch_flush(refetch_flush), .refetch_pc(refetch_pc), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   // reference model: one held entry plus the number of cycles it has been held
   bit          m_valid, m_tlb, m_rf_we, m_csr_re, m_csr_we, m_ertn;
   logic [31:0] m_pc, m_wdata, m_fva;
   logic [4:0]  m_waddr;
   logic [13:0] m_num;
   logic [5:0]  m_exc;
   logic [2:0]  m_op;
   int          m_age, m_cnt;
   bit          e_noexc, e_commit, e_refetch, e_flush, e_allow;

   always @* begin
      e_noexc   = (m_exc == 6'd0);
      e_commit  = m_valid && (!m_tlb || (m_age >= 1 && tlb_ack));
      e_refetch = e_commit && e_noexc && (m_op != 3'd0 || (m_csr_we &&
                  (m_num == 14'h0 || m_num == 14'h18 || m_num == 14'h180 || m_num == 14'h181)));
      e_flush   = e_commit && (!e_noexc || m_ertn || e_refetch);
      e_allow   = !m_valid || (e_commit && !e_flush);
   end

   always @(posedge clk) begin
      bit c, a, n;
      c = e_commit; a = e_allow; n = e_noexc;
      if (reset) begin
         m_valid = 0; m_cnt = 0; m_exc = 0; m_op = 0; m_tlb = 0; m_age = 0;
         m_rf_we = 0; m_csr_re = 0; m_csr_we = 0; m_ertn = 0; m_num = 0;
      end else begin
         if (c && n) m_cnt = (m_cnt + 1) % (1 << CW);
         if (mem_to_wb_valid && a) begin
            m_valid = 1; m_age = 0;
            m_pc = mem_pc; m_rf_we = mem_rf_we; m_waddr = mem_rf_waddr; m_wdata = mem_rf_wdata;
            m_csr_re = mem_csr_re; m_csr_we = mem_csr_we; m_num = mem_csr_num;
            m_exc = mem_exc; m_ertn = mem_ertn; m_fva = mem_fault_vaddr; m_op = mem_tlb_op;
            m_tlb = (mem_tlb_op != 3'd0) && (mem_exc == 6'd0);
         end else if (c) begin
            m_valid = 0;
         end else begin
            m_age = m_age + 1;
         end
      end
   end

   task automatic cyc;
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs;
      mem_to_wb_valid = 0; mem_pc = 0; mem_rf_we = 0; mem_rf_waddr = 0; mem_rf_wdata = 0;
      mem_csr_re = 0; mem_csr_we = 0; mem_csr_num = 0; mem_csr_mask = 0; mem_csr_wvalue = 0;
      mem_exc = 0; mem_ertn = 0; mem_fault_vaddr = 0; mem_tlb_op = 0; csr_rvalue = 0; tlb_ack = 0;
   endtask

   task automatic do_reset;
      reset = 1; clear_inputs();
      cyc(); cyc();
      reset = 0;
   endtask

   task automatic test_reset;
      do_reset(); #1;
      checks++;
      if ({wb_valid, wb_allowin, rf_we, csr_re, csr_we, ertn_flush, tlb_req, refetch_flush, fwd_valid} !== 9'b010000000) begin
         failures++; $display("FAIL reset_ctrl got=%b want=010000000",
            {wb_valid, wb_allowin, rf_we, csr_re, csr_we, ertn_flush, tlb_req, refetch_flush, fwd_valid});
      end
      checks++;
      if (retire_cnt !== '0 || wb_exc !== 6'd0 || tlb_op !== 3'd0) begin
         failures++; $display("FAIL reset_regs cnt=%0d exc=%h op=%b want 0", retire_cnt, wb_exc, tlb_op);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      mem_to_wb_valid = 1; mem_rf_we = 1; mem_rf_waddr = 5'd3; mem_rf_wdata = 32'h1234; mem_pc = 32'h1C00_0000;
      for (int i = 0; i < 2; i++) begin
         cyc(); #1;
         checks++;
         if (wb_valid !== 1 || rf_we !== 1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h1234 || wb_allowin !== 1) begin
            failures++; $display("FAIL b2b_commit%0d valid=%b we=%b addr=%0d data=%h allowin=%b want 1 1 3 1234 1",
               i, wb_valid, rf_we, rf_waddr, rf_wdata, wb_allowin);
         end
         checks++;
         if (retire_cnt !== CW'(i)) begin
            failures++; $display("FAIL b2b_cnt%0d got=%0d want=%0d", i, retire_cnt, i);
         end
      end
      mem_to_wb_valid = 0;
      cyc(); #1;
      checks++;
      if (retire_cnt !== CW'(2) || wb_valid !== 0) begin
         failures++; $display("FAIL b2b_final cnt=%0d valid=%b want 2 0", retire_cnt, wb_valid);
      end
      clear_inputs();
   endtask

   task automatic test_csr_read;
      do_reset();
      mem_to_wb_valid = 1; mem_csr_re = 1; mem_csr_num = 14'h5; mem_rf_we = 1; mem_rf_waddr = 5'd7;
      mem_rf_wdata = 32'hDEAD;
      cyc();
      clear_inputs(); csr_rvalue = 32'hABCD; #1;
      checks++;
      if (csr_re !== 1 || csr_num !== 14'h5 || rf_wdata !== 32'hABCD || rf_we !== 1 || csr_we !== 0) begin
         failures++; $display("FAIL csr_read re=%b num=%h data=%h we=%b csr_we=%b want 1 5 abcd 1 0",
            csr_re, csr_num, rf_wdata, rf_we, csr_we);
      end
      cyc();
   endtask

   task automatic test_tlb_wait;
      do_reset();
      mem_to_wb_valid = 1; mem_tlb_op = 3'(1 << TLB_OP_WR); mem_pc = 32'h1C00_0100;
      cyc();
      mem_tlb_op = 0; mem_pc = 32'h2000; mem_rf_we = 1; mem_rf_waddr = 5'd9; #1;
      checks++;
      if (wb_allowin !== 0 || tlb_req !== 0) begin
         failures++; $display("FAIL tlb_issue allowin=%b req=%b want 0 0", wb_allowin, tlb_req);
      end
      cyc();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (tlb_req !== 1 || tlb_op !== 3'b100 || wb_allowin !== 0 || refetch_flush !== 0) begin
            failures++; $display("FAIL tlb_wait%0d req=%b op=%b allowin=%b rf=%b want 1 100 0 0",
               i, tlb_req, tlb_op, wb_allowin, refetch_flush);
         end
         cyc();
      end
      tlb_ack = 1; #1;
      checks++;
      if (refetch_flush !== 1 || refetch_pc !== 32'h1C00_0104 || wb_allowin !== 0) begin
         failures++; $display("FAIL tlb_ack rf=%b pc=%h allowin=%b want 1 1c000104 0",
            refetch_flush, refetch_pc, wb_allowin);
      end
      cyc();
      tlb_ack = 0; #1;
      checks++;
      if (wb_valid !== 0 || retire_cnt !== CW'(1)) begin
         failures++; $display("FAIL tlb_after valid=%b cnt=%0d want 0 1", wb_valid, retire_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_exception;
      do_reset();
      mem_to_wb_valid = 1; mem_exc = 6'b000100; mem_rf_we = 1; mem_csr_we = 1; mem_csr_num = 14'h18;
      mem_fault_vaddr = 32'hBAD0_0000;
      cyc();
      mem_exc = 0; mem_csr_we = 0; mem_fault_vaddr = 0; #1;
      checks++;
      if (wb_exc !== 6'h04 || rf_we !== 0 || csr_we !== 0 || wb_allowin !== 0 || refetch_flush !== 0) begin
         failures++; $display("FAIL exc_commit exc=%h we=%b csr_we=%b allowin=%b rf=%b want 04 0 0 0 0",
            wb_exc, rf_we, csr_we, wb_allowin, refetch_flush);
      end
      checks++;
      if (wb_fault_vaddr !== 32'hBAD0_0000 || fwd_valid !== 0) begin
         failures++; $display("FAIL exc_fault va=%h fwd=%b want bad00000 0", wb_fault_vaddr, fwd_valid);
      end
      cyc();
      mem_to_wb_valid = 0; #1;
      checks++;
      if (wb_valid !== 0 || retire_cnt !== '0) begin
         failures++; $display("FAIL exc_after valid=%b cnt=%0d want 0 0", wb_valid, retire_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_csr_refetch;
      logic [13:0] nums [2];
      nums[0] = 14'h18; nums[1] = 14'h5;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         mem_to_wb_valid = 1; mem_csr_we = 1; mem_csr_num = nums[k];
         mem_csr_mask = 32'hFFFF_FFFF; mem_csr_wvalue = 32'(k + 1);
         cyc();
         clear_inputs(); #1;
         checks++;
         if (csr_we !== 1 || refetch_flush !== (k == 0) || csr_wvalue !== 32'(k + 1)) begin
            failures++; $display("FAIL csr_refetch num=%h we=%b rf=%b val=%h want 1 %0d %0d",
               nums[k], csr_we, refetch_flush, csr_wvalue, (k == 0), k + 1);
         end
         cyc();
      end
   endtask

   task automatic test_reset_in_tlb_wait;
      do_reset();
      mem_to_wb_valid = 1; mem_tlb_op = 3'(1 << TLB_OP_FILL);
      cyc();
      clear_inputs();
      cyc(); #1;
      checks++;
      if (tlb_req !== 1) begin
         failures++; $display("FAIL rstwait_req got=%b want 1", tlb_req);
      end
      reset = 1;
      cyc(); #1;
      checks++;
      if (tlb_req !== 0 || wb_valid !== 0) begin
         failures++; $display("FAIL rstwait_drop req=%b valid=%b want 0 0", tlb_req, wb_valid);
      end
      reset = 0; tlb_ack = 1;
      cyc(); #1;
      checks++;
      if (retire_cnt !== '0 || refetch_flush !== 0 || wb_valid !== 0 || tlb_req !== 0) begin
         failures++; $display("FAIL rstwait_late cnt=%0d rf=%b valid=%b req=%b want 0 0 0 0",
            retire_cnt, refetch_flush, wb_valid, tlb_req);
      end
      clear_inputs();
   endtask

   task automatic test_random;
      do_reset();
      for (int cyc_n = 0; cyc_n < 800; cyc_n++) begin
         reset           = ($urandom_range(0, 49) == 0);
         mem_to_wb_valid = ($urandom_range(0, 9) < 7);
         mem_pc          = $urandom & 32'hFFFF_FFFC;
         mem_rf_we       = 1'($urandom);
         mem_rf_waddr    = 5'($urandom);
         mem_rf_wdata    = $urandom;
         mem_csr_re      = ($urandom_range(0, 3) == 0);
         mem_csr_we      = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0: mem_csr_num = 14'h000;
            1: mem_csr_num = 14'h018;
            2: mem_csr_num = 14'h180;
            3: mem_csr_num = 14'h181;
            4: mem_csr_num = 14'h005;
            default: mem_csr_num = 14'h042;
         endcase
         mem_csr_mask    = $urandom;
         mem_csr_wvalue  = $urandom;
         mem_exc         = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         mem_ertn        = ($urandom_range(0, 19) == 0);
         mem_fault_vaddr = $urandom;
         case ($urandom_range(0, 9))
            0: mem_tlb_op = 3'b100;
            1: mem_tlb_op = 3'b010;
            2: mem_tlb_op = 3'b001;
            default: mem_tlb_op = 3'b000;
         endcase
         csr_rvalue = $urandom;
         tlb_ack    = ($urandom_range(0, 9) < 4);
         #1;
         checks++;
         if (wb_valid !== m_valid || wb_allowin !== e_allow) begin
            failures++; $display("FAIL rnd_hs c=%0d valid=%b allowin=%b want %b %b",
               cyc_n, wb_valid, wb_allowin, m_valid, e_allow);
         end
         checks++;
         if (rf_we !== (e_commit && e_noexc && m_rf_we) || csr_we !== (e_commit && e_noexc && m_csr_we)
             || fwd_valid !== (m_valid && m_rf_we && e_noexc)) begin
            failures++; $display("FAIL rnd_we c=%0d rf_we=%b csr_we=%b fwd=%b want %b %b %b", cyc_n,
               rf_we, csr_we, fwd_valid, e_commit && e_noexc && m_rf_we,
               e_commit && e_noexc && m_csr_we, m_valid && m_rf_we && e_noexc);
         end
         checks++;
         if (wb_exc !== (e_commit ? m_exc : 6'd0) || ertn_flush !== (e_commit && e_noexc && m_ertn)
             || refetch_flush !== e_refetch) begin
            failures++; $display("FAIL rnd_flush c=%0d exc=%h ertn=%b rf=%b want %h %b %b", cyc_n,
               wb_exc, ertn_flush, refetch_flush, e_commit ? m_exc : 6'd0,
               e_commit && e_noexc && m_ertn, e_refetch);
         end
         checks++;
         if (tlb_req !== (m_valid && m_tlb && m_age >= 1)
             || (tlb_req && tlb_op !== m_op)) begin
            failures++; $display("FAIL rnd_tlb c=%0d req=%b op=%b want %b %b", cyc_n,
               tlb_req, tlb_op, m_valid && m_tlb && m_age >= 1, m_op);
         end
         checks++;
         if (retire_cnt !== CW'(m_cnt)) begin
            failures++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", cyc_n, retire_cnt, m_cnt);
         end
         if (m_valid) begin
            checks++;
            if (rf_waddr !== m_waddr || rf_wdata !== (m_csr_re ? csr_rvalue : m_wdata)
                || csr_re !== m_csr_re || csr_num !== m_num || refetch_pc !== m_pc + 32'd4
                || wb_fault_vaddr !== m_fva) begin
               failures++; $display("FAIL rnd_data c=%0d addr=%0d data=%h re=%b num=%h rpc=%h fva=%h want %0d %h %b %h %h %h",
                  cyc_n, rf_waddr, rf_wdata, csr_re, csr_num, refetch_pc, wb_fault_vaddr,
                  m_waddr, m_csr_re ? csr_rvalue : m_wdata, m_csr_re, m_num, m_pc + 32'd4, m_fva);
            end
         end
         cyc();
      end
      reset = 0;
      clear_inputs();
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_back_to_back();
      test_csr_read();
      test_tlb_wait();
      test_exception();
      test_csr_refetch();
      test_reset_in_tlb_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
